// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute over the shared
// ALU, register file and unified memory, stalls on memory wait states and counts retirements.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ImmSrc,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BEQ, TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign instret = instret_q;

  // Outputs are forced low combinationally while reset is held, so they drop without waiting for a clock.
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ImmSrc    = 2'b00;
    halted    = 1'b0;
    if (rst_n) begin
      unique case (op)
        OP_SW:   ImmSrc = 2'b01;
        OP_BEQ:  ImmSrc = 2'b10;
        OP_JAL:  ImmSrc = 2'b11;
        default: ImmSrc = 2'b00;
      endcase
      case (state_q)
        FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
          if (mem_ready) state_d = DECODE;
        end
        DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          case (op)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_R:         state_d = EXECR;
            OP_I:         state_d = EXECI;
            OP_JAL:       state_d = JAL;
            OP_BEQ:       state_d = BEQ;
            default:      state_d = TRAP;
          endcase
        end
        MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
          if (mem_ready) state_d = MEMWB;
        end
        MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
          retire    = 1'b1;
          state_d   = FETCH;
        end
        MEMWRITE: begin
          mem_req  = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = mem_ready;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = FETCH;
          end
        end
        EXECR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b00;
          ALUOp   = 2'b10;
          state_d = ALUWB;
        end
        EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
          state_d = ALUWB;
        end
        // Target was latched into ALUOut during DECODE; the ALU now forms the link OldPC+4.
        JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
          state_d = ALUWB;
        end
        ALUWB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          state_d  = FETCH;
        end
        BEQ: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b00;
          ALUOp   = 2'b01;
          PCWrite = zero;
          retire  = 1'b1;
          state_d = FETCH;
        end
        TRAP: begin
          halted  = 1'b1;
          state_d = TRAP;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expectations are queued as stimulus is
// planned, then replayed against the DUT and popped/compared each cycle.
module tb_multicycle_controller;

  localparam int CNT_W = 4;

  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5;
  localparam int S_ER = 6, S_EI = 7, S_AW = 8, S_J = 9, S_B = 10, S_T = 11, S_RST = 12;

  localparam logic [6:0] LW = 7'h03, SW = 7'h23, RT = 7'h33, IT = 7'h13;
  localparam logic [6:0] JL = 7'h6F, BQ = 7'h63, BAD = 7'h7F;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       op = 7'h00;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, halted;
  logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [CNT_W-1:0] instret;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, ImmSrc, halted};

  typedef struct {
    int          st;
    logic [6:0]  op;
    logic        rdy;
    logic        z;
    logic        rstn;
    logic [16:0] exp;
    logic [CNT_W-1:0] cnt;
  } ent_t;

  ent_t             sb[$];
  logic [CNT_W-1:0] mcnt = '0;
  int               n_asserts = 0;
  int               n_fail = 0;
  int               step = 0;

  function automatic logic [16:0] expo(input int st, input logic [6:0] o, input logic rdy,
                                       input logic z);
    logic mreq, adr, irw, pcw, mw, rw, hlt;
    logic [1:0] res, a, b, aop, imm;
    {mreq, adr, irw, pcw, mw, rw, hlt} = '0;
    {res, a, b, aop} = '0;
    imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
    case (st)
      S_F:   begin mreq = 1; b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
      S_D:   begin a = 2'b01; b = 2'b01; end
      S_MA:  begin a = 2'b10; b = 2'b01; end
      S_MR:  begin mreq = 1; adr = 1; end
      S_MWB: begin res = 2'b01; rw = 1; end
      S_MW:  begin mreq = 1; adr = 1; mw = rdy; end
      S_ER:  begin a = 2'b10; aop = 2'b10; end
      S_EI:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      S_J:   begin a = 2'b01; b = 2'b10; pcw = 1; end
      S_AW:  rw = 1;
      S_B:   begin a = 2'b10; aop = 2'b01; pcw = z; end
      S_T:   hlt = 1;
      default: ;
    endcase
    return {mreq, adr, irw, pcw, mw, rw, res, a, b, aop, imm, hlt};
  endfunction

  task automatic push(input int st, input logic [6:0] o, input logic rdy, input logic z,
                      input logic rstn, input bit ret);
    ent_t e;
    e.st = st; e.op = o; e.rdy = rdy; e.z = z; e.rstn = rstn;
    if (!rstn) begin
      e.exp = '0;
      e.cnt = '0;
      mcnt  = '0;
    end else begin
      e.exp = expo(st, o, rdy, z);
      e.cnt = mcnt;
      if (ret) mcnt = mcnt + 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic rst_cycle(input logic [6:0] o);
    push(S_RST, o, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fetch(input logic [6:0] o, input int waits);
    for (int i = 0; i < waits; i++) push(S_F, o, 1'b0, 1'b0, 1'b1, 1'b0);
    push(S_F, o, 1'b1, 1'b0, 1'b1, 1'b0);
    push(S_D, o, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_lw(input int fw, input int mw);
    fetch(LW, fw);
    push(S_MA, LW, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < mw; i++) push(S_MR, LW, 1'b0, 1'b0, 1'b1, 1'b0);
    push(S_MR, LW, 1'b1, 1'b0, 1'b1, 1'b0);
    push(S_MWB, LW, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic do_sw(input int mw);
    fetch(SW, 0);
    push(S_MA, SW, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < mw; i++) push(S_MW, SW, 1'b0, 1'b0, 1'b1, 1'b0);
    push(S_MW, SW, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic do_alu(input logic [6:0] o);
    fetch(o, 0);
    push((o == RT) ? S_ER : (o == IT) ? S_EI : S_J, o, 1'b1, 1'b0, 1'b1, 1'b0);
    push(S_AW, o, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic do_beq(input logic z);
    fetch(BQ, 0);
    push(S_B, BQ, 1'b1, z, 1'b1, 1'b1);
  endtask

  task automatic run_sb();
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rst_n = e.rstn; op = e.op; mem_ready = e.rdy; zero = e.z;
      #1;
      n_asserts++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL outs step=%0d st=%0d observed=%h expected=%h", step, e.st, obs, e.exp);
      end
      n_asserts++;
      assert (instret === e.cnt) else begin
        n_fail++;
        $error("FAIL instret step=%0d st=%0d observed=%0d expected=%0d", step, e.st, instret, e.cnt);
      end
      step++;
    end
  endtask

  initial begin
    rst_cycle(LW);
    rst_cycle(LW);
    do_lw(0, 0);
    do_sw(3);
    do_beq(1'b1);
    do_beq(1'b0);
    do_alu(RT);
    do_alu(IT);
    do_alu(JL);
    do_lw(2, 2);
    fetch(BAD, 0);
    for (int i = 0; i < 100; i++) push(S_T, BAD, 1'b1, 1'b0, 1'b1, 1'b0);
    rst_cycle(BAD);
    for (int i = 0; i < 17; i++) do_alu(RT);
    fetch(LW, 0);
    push(S_MA, LW, 1'b1, 1'b0, 1'b1, 1'b0);
    push(S_MR, LW, 1'b0, 1'b0, 1'b0, 1'b0);
    do_lw(0, 0);
    do_sw(0);
    run_sb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
